// File: rtl/product_acc_pkg.sv
// Shared types and default widths for the product accumulator slice.
package product_acc_pkg;

  localparam int PROD_W_DEF = 32;
  localparam int ACC_W_DEF  = 40;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/product_accumulator_if.sv
// Burst/product/result handshake bundle between the multiplier side and the accumulator.
interface product_accumulator_if
  import product_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
);

  logic              start;
  logic [LEN_W-1:0]  len;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] product;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc;
  logic              busy;
  logic              overflow;

  modport master (
    output start, len, prod_valid, product, acc_ready,
    input  prod_ready, acc_valid, acc, busy, overflow
  );

  modport slave (
    input  start, len, prod_valid, product, acc_ready,
    output prod_ready, acc_valid, acc, busy, overflow
  );

endinterface

// File: rtl/product_accumulator_acc_add_sat.sv
// Unsigned accumulator adder with carry-out; clamps to all-ones when PRODUCT_ACC_SAT_EN is defined.
module acc_add_sat #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] add_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              carry_o
);

  logic [ACC_W:0] raw_sum;

  assign raw_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, add_i};
  assign carry_o = raw_sum[ACC_W];

`ifdef PRODUCT_ACC_SAT_EN
  // A saturated sum re-carries on any non-zero addend, so it stays pinned at all-ones.
  assign sum_o = carry_o ? {ACC_W{1'b1}} : raw_sum[ACC_W-1:0];
`else
  assign sum_o = raw_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Burst accumulator for multiplier products: IDLE -> ACCUM -> DONE with held result handshake.
// Optional saturation instead of wrap-around is selected by defining PRODUCT_ACC_SAT_EN.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  product_accumulator_if.slave  bus
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic               beat;
  logic [ACC_W-1:0]   sum;
  logic               carry;

  assign beat = (state_q == ACCUM) && bus.prod_valid;

  acc_add_sat #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc_i   (acc_q),
    .add_i   (bus.product),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : ACCUM;
      ACCUM:   if (beat && count_q == LEN_W'(1)) state_d = DONE;
      DONE:    if (bus.acc_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && bus.start) begin
      acc_d   = '0;
      ovf_d   = 1'b0;
      count_d = bus.len;
    end else if (beat) begin
      acc_d   = sum;
      count_d = count_q - LEN_W'(1);
      ovf_d   = ovf_q | carry;
    end
  end

  always_comb begin
    bus.prod_ready = (state_q == ACCUM);
    bus.acc_valid  = (state_q == DONE);
    bus.busy       = (state_q == ACCUM) || (state_q == DONE);
    bus.acc        = acc_q;
    bus.overflow   = ovf_q;
  end

endmodule
